// File: rtl/phase2speed_mc.sv
// rtl/phase2speed_mc.sv - multi-channel block-averaging phase-difference to speed converter
module phase2speed_mc #(
    parameter int NCH     = 4,
    parameter int PHASE_W = 19,
    parameter int SPEED_W = 16,
    parameter int MAXLOG  = 8,
    parameter int KSHIFT  = 10,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sample,
    input  logic [CW-1:0]             chan,
    input  logic signed [PHASE_W-1:0] phase,
    input  logic [3:0]                meanlen,
    input  logic [15:0]               kscale,
    input  logic                      clear,
    output logic signed [SPEED_W-1:0] speed,
    output logic [CW-1:0]             speed_chan,
    output logic                      ready,
    output logic                      sat
);
    localparam int ACC_W  = PHASE_W + MAXLOG;
    localparam int PROD_W = ACC_W + 17;
    localparam int R_W    = PROD_W - KSHIFT;
    localparam logic signed [R_W-1:0] SMAX = {{(R_W-SPEED_W+1){1'b0}}, {(SPEED_W-1){1'b1}}};
    localparam logic signed [R_W-1:0] SMIN = {{(R_W-SPEED_W+1){1'b1}}, {(SPEED_W-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1) << (KSHIFT - 1);

    logic signed [ACC_W-1:0] acc [NCH];
    logic [MAXLOG-1:0]       cnt [NCH];
    logic [3:0]              len [NCH];

    logic                    s1_valid, s2_valid, s3_valid;
    logic signed [ACC_W-1:0] s1_sum;
    logic [3:0]              s1_len;
    logic [CW-1:0]           s1_chan, s2_chan, s3_chan;
    logic signed [PROD_W-1:0] s2_prod;
    logic signed [R_W-1:0]   s3_r;

    logic                    chan_ok;
    logic [CW-1:0]           idx;
    logic [3:0]              ml_clamp;
    logic [MAXLOG-1:0]       cur_cnt;
    logic [3:0]              cur_len;
    logic [MAXLOG:0]         blk_mask;
    logic                    blk_last;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] mean;
    logic signed [PROD_W-1:0] mean_x, gain_x, prod, rnd;

    // Out-of-range channels are redirected to index 0 only to keep the array read legal.
    always_comb begin
        chan_ok  = (32'(chan) < NCH);
        idx      = chan_ok ? chan : '0;
        ml_clamp = (meanlen > 4'(MAXLOG)) ? 4'(MAXLOG) : meanlen;
        cur_cnt  = cnt[idx];
        cur_len  = (cur_cnt == '0) ? ml_clamp : len[idx];
        blk_mask = (MAXLOG+1)'((32'd1 << cur_len) - 32'd1);
        blk_last = ({1'b0, cur_cnt} == blk_mask);
        sum      = acc[idx] + {{MAXLOG{phase[PHASE_W-1]}}, phase};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
                len[i] <= '0;
            end
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_len   <= '0;
            s1_chan  <= '0;
        end else if (clear) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= 1'b0;
            if (sample && chan_ok) begin
                if (cur_cnt == '0)
                    len[idx] <= ml_clamp;
                if (blk_last) begin
                    s1_valid <= 1'b1;
                    s1_sum   <= sum;
                    s1_len   <= cur_len;
                    s1_chan  <= chan;
                    acc[idx] <= '0;
                    cnt[idx] <= '0;
                end else begin
                    acc[idx] <= sum;
                    cnt[idx] <= cur_cnt + MAXLOG'(1);
                end
            end
        end
    end

    always_comb begin
        mean   = s1_sum >>> s1_len;
        mean_x = {{(PROD_W-ACC_W){mean[ACC_W-1]}}, mean};
        gain_x = {{(PROD_W-16){1'b0}}, kscale};
        prod   = mean_x * gain_x;
        rnd    = s2_prod + HALF;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_chan  <= '0;
            s3_valid <= 1'b0;
            s3_r     <= '0;
            s3_chan  <= '0;
        end else if (clear) begin
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_prod  <= prod;
            s2_chan  <= s1_chan;
            s3_valid <= s2_valid;
            s3_r     <= R_W'(rnd >>> KSHIFT);
            s3_chan  <= s2_chan;
        end
    end

    // Result registers hold across clear; only the ready pulse is suppressed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            speed      <= '0;
            speed_chan <= '0;
            ready      <= 1'b0;
            sat        <= 1'b0;
        end else begin
            ready <= s3_valid && !clear;
            if (s3_valid && !clear) begin
                speed_chan <= s3_chan;
                if (s3_r > SMAX) begin
                    speed <= SMAX[SPEED_W-1:0];
                    sat   <= 1'b1;
                end else if (s3_r < SMIN) begin
                    speed <= SMIN[SPEED_W-1:0];
                    sat   <= 1'b1;
                end else begin
                    speed <= s3_r[SPEED_W-1:0];
                    sat   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_phase2speed_mc.sv
// tb/tb_phase2speed_mc.sv - scoreboard bench for phase2speed_mc
module tb_phase2speed_mc;
    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               sample = 1'b0;
    logic [1:0]         chan = '0;
    logic signed [18:0] phase = '0;
    logic [3:0]         meanlen = '0;
    logic [15:0]        kscale = '0;
    logic               clear = 1'b0;
    logic signed [15:0] speed;
    logic [1:0]         speed_chan;
    logic               ready;
    logic               sat;

    phase2speed_mc #(.NCH(4), .PHASE_W(19), .SPEED_W(16), .MAXLOG(8), .KSHIFT(10)) dut (
        .clock(clock), .reset(reset), .sample(sample), .chan(chan), .phase(phase),
        .meanlen(meanlen), .kscale(kscale), .clear(clear), .speed(speed),
        .speed_chan(speed_chan), .ready(ready), .sat(sat)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int   speed;
        int   ch;
        int   sat;
        int   cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  ch;
        int          ph;
        logic [15:0] ks;
        int          exp_speed;
        int          exp_sat;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (ready) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready: got speed %0d chan %0d expected no ready", speed, speed_chan);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("ready_cycle", cyc, mon_e.cyc);
                    chk("speed", int'(speed), mon_e.speed);
                    chk("speed_chan", int'(speed_chan), mon_e.ch);
                    chk("sat", int'(sat), mon_e.sat);
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                mon_e = sbq.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_ready: got no ready by cycle %0d expected speed %0d", cyc, mon_e.speed);
            end
        end
    end

    task automatic send(input logic [1:0] ch, input int ph, input logic [3:0] ml,
                        input logic [15:0] ks, input bit push, input int es, input int esat);
        sample  = 1'b1;
        chan    = ch;
        phase   = 19'(ph);
        meanlen = ml;
        kscale  = ks;
        if (push) sbq.push_back('{es, int'(ch), esat, cyc + 4});
        @(negedge clock);
        sample = 1'b0;
    endtask

    task automatic idle(input int n);
        sample = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    vec_t vt[10];

    initial begin
        vt[0] = '{2'd0,   1000, 16'd1024,   1000, 0};
        vt[1] = '{2'd1,  -1000, 16'd512,    -500, 0};
        vt[2] = '{2'd2,      3, 16'd1536,      5, 0};
        vt[3] = '{2'd3,     -3, 16'd1536,     -4, 0};
        vt[4] = '{2'd0,  32767, 16'd1024,  32767, 0};
        vt[5] = '{2'd1,  32768, 16'd1024,  32767, 1};
        vt[6] = '{2'd2, -32768, 16'd1024, -32768, 0};
        vt[7] = '{2'd3, -32769, 16'd1024, -32768, 1};
        vt[8] = '{2'd0,      7, 16'd0,         0, 0};
        vt[9] = '{2'd1,    100, 16'd65535,  6400, 0};

        repeat (3) @(negedge clock);
        chk("reset_speed", int'(speed), 0);
        chk("reset_chan", int'(speed_chan), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_sat", int'(sat), 0);
        reset = 1'b1;
        idle(2);

        // single-sample blocks covering rounding, gain and saturation edges
        for (int i = 0; i < 10; i++) begin
            send(vt[i].ch, vt[i].ph, 4'd0, vt[i].ks, 1'b1, vt[i].exp_speed, vt[i].exp_sat);
            idle(3);
        end
        idle(4);

        send(2'd0, 100, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd0, 200, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd0, 300, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd0, 400, 4'd2, 16'd1024, 1'b1, 250, 0);
        idle(6);

        send(2'd1,  10, 4'd1, 16'd1024, 1'b0, 0, 0);
        send(2'd2,  -7, 4'd1, 16'd1024, 1'b0, 0, 0);
        send(2'd1,  30, 4'd1, 16'd1024, 1'b1, 20, 0);
        send(2'd2,  -2, 4'd1, 16'd1024, 1'b1, -5, 0);
        idle(6);

        send(2'd0,  200000, 4'd0, 16'd1024, 1'b1,  32767, 1);
        send(2'd0, -200000, 4'd0, 16'd1024, 1'b1, -32768, 1);
        idle(6);

        for (int i = 0; i < 256; i++)
            send(2'd0, 5, (i < 10) ? 4'd15 : 4'd1, 16'd1024, (i == 255), 5, 0);
        idle(6);

        send(2'd3, 5, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd3, 5, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd0, 50, 4'd0, 16'd1024, 1'b0, 0, 0);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        idle(5);
        send(2'd3,  8, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd3,  8, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd3,  8, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd3, 12, 4'd2, 16'd1024, 1'b1, 9, 0);
        idle(6);

        send(2'd1, 40, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd1, 40, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd2,  9, 4'd0, 16'd1024, 1'b0, 0, 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_speed", int'(speed), 0);
        chk("async_rst_chan", int'(speed_chan), 0);
        chk("async_rst_ready", int'(ready), 0);
        @(negedge clock);
        idle(3);
        reset = 1'b1;
        idle(2);
        send(2'd1, 40, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd1, 40, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd1, 40, 4'd2, 16'd1024, 1'b0, 0, 0);
        send(2'd1, 44, 4'd2, 16'd1024, 1'b1, 41, 0);
        idle(10);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
